// File: rtl/serial_deserializer.sv
// serial_deserializer: LSB-first bit-serial to parallel receiver.
// Checks frame length against ser_last; one staging slot absorbs back-pressure.
module serial_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_valid,
    input  logic             ser_bit,
    input  logic             ser_last,
    output logic             ser_ready,
    output logic [WIDTH-1:0] par_data,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    localparam logic [1:0] RECV   = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] RESYNC = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-2:0] shreg;
    logic [WIDTH-1:0] stage;
    logic [WIDTH-1:0] word;
    logic             beat;
    logic             drain;
    logic             at_end;

    assign ser_ready = !rst && (state != HOLD);
    assign beat      = ser_valid && ser_ready;
    assign drain     = par_valid && par_ready;
    assign at_end    = (cnt == LAST_IDX);
    assign word      = {ser_bit, shreg};

    // Capture each received bit at its position; the top bit goes straight to the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
        end else if (beat && state == RECV && !at_end) begin
            for (int i = 0; i < WIDTH - 1; i++) begin
                if (cnt == CW'(i)) begin
                    shreg[i] <= ser_bit;
                end
            end
        end
    end

    // Frame sequencing, output register, staging slot and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RECV;
            cnt       <= '0;
            stage     <= '0;
            par_data  <= '0;
            par_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (drain) begin
                par_valid <= 1'b0;
            end
            case (state)
                RECV: begin
                    if (beat) begin
                        if (at_end && ser_last) begin
                            cnt <= '0;
                            if (!par_valid || par_ready) begin
                                par_data  <= word;
                                par_valid <= 1'b1;
                            end else begin
                                stage <= word;
                                state <= HOLD;
                            end
                        end else if (ser_last) begin
                            frame_err <= 1'b1;
                            cnt       <= '0;
                        end else if (at_end) begin
                            frame_err <= 1'b1;
                            cnt       <= '0;
                            state     <= RESYNC;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (drain) begin
                        par_data  <= stage;
                        par_valid <= 1'b1;
                        state     <= RECV;
                    end
                end
                RESYNC: begin
                    if (beat && ser_last) begin
                        cnt   <= '0;
                        state <= RECV;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= RECV;
                end
            endcase
        end
    end

endmodule
